// File: rtl/counter_sequencer_if.sv
// Command channel of the counter sequencer: valid/ready command bus plus
// the completion pulse and step count returned to the master.
interface counter_sequencer_if #(
  parameter int WIDTH = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             done;
  logic [WIDTH-1:0] steps;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, done, steps
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, done, steps
  );
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for an up/down counter: clears, loads, or runs
// the counter to a target and stops it exactly there, reporting the steps taken.
module counter_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_sequencer_if.slave   cmd,
  output logic                 ctr_reset,
  output logic                 ctr_load,
  output logic [WIDTH-1:0]     ctr_data,
  output logic                 ctr_count_up,
  input  logic [WIDTH-1:0]     ctr_count
);

  localparam logic [1:0] OP_CLEAR   = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_UP_TO   = 2'b10;
  localparam logic [1:0] OP_DOWN_TO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] tgt;
  logic             dir;
  logic             done_q;
  logic [WIDTH-1:0] steps_q;
  logic [WIDTH-1:0] step_cnt;
  logic             at_target;

  assign at_target     = (ctr_count == tgt);
  assign cmd.cmd_ready = (state == IDLE) && !reset;
  assign cmd.done      = done_q;
  assign cmd.steps     = steps_q;
  assign ctr_reset     = reset || (state == CLR);

  // While idle the counter is frozen by reloading it with hold every cycle.
  always_comb begin
    ctr_load     = 1'b0;
    ctr_data     = hold;
    ctr_count_up = 1'b0;
    unique case (state)
      IDLE: ctr_load = 1'b1;
      RUN: begin
        ctr_count_up = dir;
        if (at_target) begin
          ctr_load = 1'b1;
          ctr_data = tgt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      tgt      <= '0;
      dir      <= 1'b0;
      done_q   <= 1'b0;
      steps_q  <= '0;
      step_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            unique case (cmd.cmd_op)
              OP_CLEAR: state <= CLR;
              OP_LOAD: begin
                hold   <= cmd.cmd_arg;
                done_q <= 1'b1;
              end
              OP_UP_TO, OP_DOWN_TO: begin
                tgt      <= cmd.cmd_arg;
                dir      <= (cmd.cmd_op == OP_UP_TO);
                step_cnt <= '0;
                state    <= RUN;
              end
              default: ;
            endcase
          end
        end
        CLR: begin
          hold   <= '0;
          state  <= IDLE;
          done_q <= 1'b1;
        end
        RUN: begin
          // The stop cycle reloads tgt, so the counter lands on it and stays.
          if (at_target) begin
            steps_q <= step_cnt;
            hold    <= tgt;
            state   <= IDLE;
            done_q  <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller for the 6-bit up/down counter. It drives the counter's reset, load, data and direction inputs, and watches the counter's COUNT output.
- Accepts one command at a time over a valid/ready handshake: clear, load, count up to a target, or count down to a target.
- Stops the counter exactly on the target and reports completion plus the number of steps taken.
- Sits between a test or control master and the counter. It replaces hand-sequenced LOAD/COUNT_UP stimulus.

Parameters:
- WIDTH, 6, counter width. Applies to CMD_ARG, CTR_DATA, CTR_COUNT and STEPS.

Ports:
- CLK  input  1  clock. The sequencer and the counter share this single clock.
- RESET  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  a command is present.
- CMD_READY  output  1  the sequencer can accept a command.
- CMD_OP  input  2  00 CLEAR, 01 LOAD, 10 UP_TO, 11 DOWN_TO.
- CMD_ARG  input  WIDTH  load value (LOAD) or target value (UP_TO, DOWN_TO). Ignored for CLEAR.
- CTR_RESET  output  1  reset to the counter.
- CTR_LOAD  output  1  load strobe to the counter.
- CTR_DATA  output  WIDTH  load value to the counter.
- CTR_COUNT_UP  output  1  direction to the counter: 1 = up, 0 = down.
- CTR_COUNT  input  WIDTH  registered count from the counter.
- DONE  output  1  one-cycle pulse when a command completes.
- STEPS  output  WIDTH  step count of the last UP_TO/DOWN_TO command. Holds its value until the next such command.

Behaviour:
- Counter contract (fixed):
  - Controls are sampled on the CLK edge; reset has priority over load, and load over counting.
  - With none of these active, the counter moves by ±1 every cycle and wraps modulo 2^WIDTH.
- Registers: state (IDLE, CLR, RUN), hold (WIDTH), tgt (WIDTH), dir (1), DONE, STEPS.
- RESET: state=IDLE, hold=0, tgt=0, dir=0, DONE=0, STEPS=0. CTR_RESET=1 while RESET=1.
- CMD_READY = (state==IDLE) and not RESET. A command is accepted on an edge where CMD_VALID and CMD_READY are both 1.
- Outputs are combinational from state:
  - IDLE: CTR_LOAD=1, CTR_DATA=hold, CTR_COUNT_UP=0. The counter is frozen at hold by reloading it every cycle.
  - CLR: CTR_RESET=1, CTR_LOAD=0.
  - RUN: CTR_COUNT_UP=dir.
    - If CTR_COUNT==tgt: CTR_LOAD=1, CTR_DATA=tgt (stop cycle).
    - Otherwise CTR_LOAD=0.
- CTR_RESET = RESET or state==CLR.
- CLEAR accepted:
  - Next state is CLR; CLR lasts exactly one cycle.
  - Leaving CLR: hold=0, state=IDLE, DONE=1.
- LOAD accepted:
  - hold=CMD_ARG, DONE=1 on the next cycle, state stays IDLE.
  - The counter reads CMD_ARG one cycle after DONE rises.
- UP_TO / DOWN_TO accepted:
  - tgt=CMD_ARG, dir=(op==UP_TO), step counter cleared, state=RUN.
- RUN, each cycle:
  - CTR_COUNT!=tgt: step counter +1, counter advances.
  - CTR_COUNT==tgt: STEPS=step count, hold=tgt, state=IDLE, DONE=1.
- Target equal to the current count: completes in the first RUN cycle with STEPS=0.
- Wrap-around is legal. The run always terminates within 2^WIDTH-1 steps; STEPS never overflows.
- DONE is high for exactly one cycle per command and low otherwise.
- A new command can be accepted on the cycle DONE is high, since the state is already IDLE.
- RESET mid-command (CLR or RUN): abort immediately.
  - No DONE is produced.
  - Registers return to their reset values and the counter is reset.
- CMD_VALID with CMD_READY=0: the command is not consumed. The master must hold it stable until it is accepted.

Test Plan:
- Reset for 2 cycles, then idle 5 cycles -> CTR_RESET=1 during reset; then CTR_COUNT stays 0, CMD_READY=1, DONE=0, STEPS=0.
- LOAD 42 (101010), then UP_TO 45 -> LOAD gives a DONE pulse and CTR_COUNT=42; UP_TO gives CTR_COUNT 42→43→44→45, DONE, STEPS=3, and CTR_COUNT holds at 45 for 10+ cycles.
- LOAD 3, then DOWN_TO 60 -> the count wraps 3→2→1→0→63→62→61→60; STEPS=7; DONE once.
- LOAD 20, then UP_TO 20 -> DONE in the first RUN cycle, STEPS=0, CTR_COUNT=20.
- UP_TO 50 launched from 10, with RESET asserted after 5 RUN cycles -> no DONE, CTR_COUNT=0, STEPS=0, CMD_READY=1 after reset is released.
- Back-to-back commands CLEAR, LOAD 7, DOWN_TO 5, with CMD_VALID held high -> each is accepted only while CMD_READY=1; three DONE pulses; final CTR_COUNT=5, STEPS=2.
